// File: rtl/riscv_dmem_tcm.sv
// Data-side tightly-coupled memory for the load/store unit.
// One access in flight at a time; byte-lane stores, aligned word loads,
// misaligned/out-of-range reporting, programmable response wait states.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for dmem_req; samples and latches the request
//   S_WAIT | burning wait states; the counter counts down to zero
//   S_RESP | dmem_ack high for one cycle; held request is ignored
module riscv_dmem_tcm #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  logic [2:0]      dmem_size,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault
);

  localparam int              AW    = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH_WORDS * 4);
  localparam logic [2:0]      WS_M1 = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HWORD = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [XLEN-1:0] adr_q, d_q;
  logic            we_q;
  logic [2:0]      size_q;
  logic            mis_q, pf_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            idle_c;
  logic [XLEN-1:0] acc_adr, acc_d;
  logic            acc_we;
  logic [2:0]      acc_size;
  logic            live_mis, live_range;
  logic            acc_mis, acc_pf, acc_err;
  logic [XLEN-1:0] off_c;
  logic [AW-1:0]   idx_c;
  logic [3:0]      be_c;
  logic            fire;

  // Error checks on the live request; these are what get latched in IDLE.
  always_comb begin
    live_mis   = 1'b0;
    live_range = 1'b0;
    case (dmem_size)
      SZ_BYTE:  live_mis = 1'b0;
      SZ_HWORD: live_mis = dmem_adr[0];
      SZ_WORD:  live_mis = |dmem_adr[1:0];
      default:  live_mis = 1'b1;
    endcase
    // Unsigned wrap makes below-base addresses look huge, hence out of range.
    live_range = ((dmem_adr - BASE_ADDR) >= SPAN);
  end

  // Select the access being serviced: the live request in IDLE (zero-wait
  // completes on the sampling edge), otherwise the latched copy.
  always_comb begin
    idle_c   = (state_q == S_IDLE);
    acc_adr  = idle_c ? dmem_adr  : adr_q;
    acc_d    = idle_c ? dmem_d    : d_q;
    acc_we   = idle_c ? dmem_we   : we_q;
    acc_size = idle_c ? dmem_size : size_q;
    acc_mis  = idle_c ? live_mis  : mis_q;
    acc_pf   = idle_c ? (live_range & ~live_mis) : pf_q;
    acc_err  = acc_mis | acc_pf;
    off_c    = acc_adr - BASE_ADDR;
    idx_c    = off_c[AW+1:2];
    be_c     = 4'b0000;
    case (acc_size)
      SZ_BYTE:  be_c = 4'b0001 << acc_adr[1:0];
      SZ_HWORD: be_c = 4'b0011 << acc_adr[1:0];
      SZ_WORD:  be_c = 4'b1111;
      default:  be_c = 4'b0000;
    endcase
    fire = (idle_c && dmem_req && (WAIT_STATES == 0)) ||
           ((state_q == S_WAIT) && (cnt_q == 3'd0));
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          cnt_d   = WS_M1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and request-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      adr_q   <= '0;
      d_q     <= '0;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      mis_q   <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle_c && dmem_req) begin
        adr_q  <= dmem_adr;
        d_q    <= dmem_d;
        we_q   <= dmem_we;
        size_q <= dmem_size;
        mis_q  <= live_mis;
        pf_q   <= live_range & ~live_mis;
      end
    end
  end

  // Response registers; everything is zero outside the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_ack        <= 1'b0;
      dmem_q          <= '0;
      dmem_misaligned <= 1'b0;
      dmem_page_fault <= 1'b0;
    end else begin
      dmem_ack        <= fire;
      dmem_misaligned <= fire & acc_mis;
      dmem_page_fault <= fire & acc_pf;
      dmem_q          <= (fire && !acc_we && !acc_err) ? mem[idx_c] : '0;
    end
  end

  // Store commit on the edge that raises ack; reset abandons the write.
  always_ff @(posedge clk) begin
    if (!rst && fire && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= acc_d[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Directed bench for riscv_dmem_tcm: three instances cover zero-wait at base 0,
// one wait state at base 0x1000, and three wait states at base 0.
module tb_riscv_dmem_tcm;

  logic        clk;
  logic        rst;
  logic        req  [3];
  logic [31:0] adr  [3];
  logic [31:0] d    [3];
  logic        we   [3];
  logic [2:0]  sz   [3];
  logic        ack  [3];
  logic [31:0] q    [3];
  logic        mis  [3];
  logic        pf   [3];

  int checks = 0;
  int errors = 0;
  int ws [3] = '{0, 1, 3};

  riscv_dmem_tcm #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .dmem_req(req[0]), .dmem_adr(adr[0]), .dmem_d(d[0]),
    .dmem_we(we[0]), .dmem_size(sz[0]), .dmem_ack(ack[0]), .dmem_q(q[0]),
    .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0]));

  riscv_dmem_tcm #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(1)) u1 (
    .clk(clk), .rst(rst), .dmem_req(req[1]), .dmem_adr(adr[1]), .dmem_d(d[1]),
    .dmem_we(we[1]), .dmem_size(sz[1]), .dmem_ack(ack[1]), .dmem_q(q[1]),
    .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1]));

  riscv_dmem_tcm #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst), .dmem_req(req[2]), .dmem_adr(adr[2]), .dmem_d(d[2]),
    .dmem_we(we[2]), .dmem_size(sz[2]), .dmem_ack(ack[2]), .dmem_q(q[2]),
    .dmem_misaligned(mis[2]), .dmem_page_fault(pf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the instance idle. Returns the ack
  // latency in cycles (0 = timed out) and whether ack was still high a cycle later.
  task automatic access(input int k, input logic w, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] dd,
                        output logic [31:0] qq, output logic mm, output logic pp,
                        output int lat, output logic stuck);
    lat = 0; qq = '0; mm = 1'b0; pp = 1'b0;
    we[k] = w; sz[k] = s; adr[k] = a; d[k] = dd; req[k] = 1'b1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (ack[k]) begin
        lat = c; qq = q[k]; mm = mis[k]; pp = pf[k];
      end
    end
    req[k] = 1'b0;
    @(posedge clk); #1;
    stuck = ack[k];
  endtask

  task automatic txn(input string tag, input int k, input logic w, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] dd,
                     input logic [31:0] eq, input logic emis, input logic epf);
    logic [31:0] qq;
    logic mm, pp, stuck;
    int lat;
    access(k, w, s, a, dd, qq, mm, pp, lat, stuck);
    check(tag, {16'h0, 8'(lat), 5'b0, stuck, mm, pp, qq},
               {16'h0, 8'(1 + ws[k]), 5'b0, 1'b0, emis, epf, eq});
  endtask

  logic [10:0] ackv;
  logic [31:0] qcap;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; adr[k] = '0; d[k] = '0; we[k] = 1'b0; sz[k] = 3'd2;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_u0", {31'b0, ack[0], mis[0], pf[0], q[0]}, 64'h0);
    check("reset_u1", {31'b0, ack[1], mis[1], pf[1], q[1]}, 64'h0);
    check("reset_u2", {31'b0, ack[2], mis[2], pf[2], q[2]}, 64'h0);

    // Zero wait states, base 0
    txn("st_word_10",  0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    txn("ld_word_10",  0, 1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    txn("st_word_20",  0, 1'b1, 3'd2, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b0);
    txn("st_byte_22",  0, 1'b1, 3'd0, 32'h22, 32'h00AB0000, 32'h0, 1'b0, 1'b0);
    txn("ld_after_b",  0, 1'b0, 3'd2, 32'h20, 32'h0,        32'h11AB3344, 1'b0, 1'b0);
    txn("st_word_24",  0, 1'b1, 3'd2, 32'h24, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0);
    txn("st_hword_26", 0, 1'b1, 3'd1, 32'h26, 32'h55660000, 32'h0, 1'b0, 1'b0);
    txn("ld_after_h",  0, 1'b0, 3'd2, 32'h24, 32'h0,        32'h5566AAAA, 1'b0, 1'b0);
    txn("st_word_30",  0, 1'b1, 3'd2, 32'h30, 32'h01020304, 32'h0, 1'b0, 1'b0);
    txn("ld_hword_31", 0, 1'b0, 3'd1, 32'h31, 32'h0,        32'h0, 1'b1, 1'b0);
    txn("ld_word_32",  0, 1'b0, 3'd2, 32'h32, 32'h0,        32'h0, 1'b1, 1'b0);
    txn("st_dword_30", 0, 1'b1, 3'd3, 32'h30, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    txn("st_hword_33", 0, 1'b1, 3'd1, 32'h33, 32'hEE000000, 32'h0, 1'b1, 1'b0);
    txn("ld_30_kept",  0, 1'b0, 3'd2, 32'h30, 32'h0,        32'h01020304, 1'b0, 1'b0);
    txn("ld_byte_33",  0, 1'b0, 3'd0, 32'h33, 32'h0,        32'h01020304, 1'b0, 1'b0);
    txn("ld_qword_30", 0, 1'b0, 3'd4, 32'h30, 32'h0,        32'h0, 1'b1, 1'b0);

    // One wait state, base 0x1000
    txn("st_1ffc",     1, 1'b1, 3'd2, 32'h1FFC, 32'h0BADCAFE, 32'h0, 1'b0, 1'b0);
    txn("ld_1ffc",     1, 1'b0, 3'd2, 32'h1FFC, 32'h0,        32'h0BADCAFE, 1'b0, 1'b0);
    txn("st_1000",     1, 1'b1, 3'd2, 32'h1000, 32'h12345678, 32'h0, 1'b0, 1'b0);
    txn("ld_2000_pf",  1, 1'b0, 3'd2, 32'h2000, 32'h0,        32'h0, 1'b0, 1'b1);
    txn("ld_0ffc_pf",  1, 1'b0, 3'd2, 32'h0FFC, 32'h0,        32'h0, 1'b0, 1'b1);
    txn("ld_h2001_mis",1, 1'b0, 3'd1, 32'h2001, 32'h0,        32'h0, 1'b1, 1'b0);
    txn("st_2000_pf",  1, 1'b1, 3'd2, 32'h2000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
    txn("ld_1000_kept",1, 1'b0, 3'd2, 32'h1000, 32'h0,        32'h12345678, 1'b0, 1'b0);

    // Three wait states: back-to-back loads with req held
    txn("st_44",       2, 1'b1, 3'd2, 32'h44, 32'h0A0B0C0D, 32'h0, 1'b0, 1'b0);
    ackv = '0; qcap = '0;
    we[2] = 1'b0; sz[2] = 3'd2; adr[2] = 32'h44; req[2] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      ackv[c] = ack[2];
      if (ack[2]) qcap = qcap ^ q[2];
    end
    req[2] = 1'b0;
    check("b2b_ack_cycles", {53'b0, ackv}, {53'b0, 11'h210});
    check("b2b_data_xor",   {32'b0, qcap}, 64'h0);

    // Request dropped after one cycle still completes
    ackv = '0; qcap = '0;
    @(posedge clk); #1;
    req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    ackv[1] = ack[2];
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk); #1;
      ackv[c] = ack[2];
      if (ack[2]) qcap = q[2];
    end
    check("drop_req_ack", {53'b0, ackv}, {53'b0, 11'h010});
    check("drop_req_q",   {32'b0, qcap}, {32'b0, 32'h0A0B0C0D});

    // Reset in the middle of a waited store
    txn("st_40_pre",   2, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    we[2] = 1'b1; sz[2] = 3'd2; adr[2] = 32'h40; d[2] = 32'h00000055; req[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req[2] = 1'b0;
    check("rst_mid_outs", {31'b0, ack[2], mis[2], pf[2], q[2]}, 64'h0);
    ackv = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      ackv[c] = ack[2];
    end
    check("rst_mid_no_ack", {53'b0, ackv}, 64'h0);
    txn("ld_40_after_rst", 2, 1'b0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
